// File: rtl/gpr_csr_file_pkg.sv
// Shared types and constants for the RV32 GPR/CSR state block.
// CSR command encoding, CSR map, mstatus fields and reset values.
package rf_pkg;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_RW    = 3'd1,
        CMD_RS    = 3'd2,
        CMD_RC    = 3'd3,
        CMD_ECALL = 3'd4,
        CMD_MRET  = 3'd5
    } csr_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRAP_SAVE,
        ST_TRAP_STAT,
        ST_MRET_STAT,
        ST_DONE
    } trap_state_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Only MIE and MPIE are software-writable; MPP stays machine mode.
    localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;

    localparam logic [31:0] MCAUSE_RST  = 32'h0000_000b;
    localparam logic [31:0] ECALL_CAUSE = 32'd11;

    // New CSR value for the read-modify-write commands.
    function automatic logic [31:0] csr_new_val(
        input csr_cmd_e    cmd,
        input logic [31:0] old,
        input logic [31:0] wsrc
    );
        logic [31:0] r;
        r = old;
        unique case (cmd)
            CMD_RW:  r = wsrc;
            CMD_RS:  r = old | wsrc;
            CMD_RC:  r = old & ~wsrc;
            default: r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gpr_csr_file_trap_fsm.sv
// Trap sequencer: ECALL entry and MRET return.
// Drives the state-update strobes and the done/redirect pulse.
module csr_trap_fsm
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_ecall,
    input  logic start_mret,
    output logic ready,
    output logic save_en,
    output logic trap_stat_en,
    output logic mret_stat_en,
    output logic done,
    output logic done_is_mret
);

    trap_state_e state_q;
    trap_state_e state_d;
    logic        is_mret_q;

    // State register plus a flag telling DONE which redirect target to use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            is_mret_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_ecall) begin
                is_mret_q <= 1'b0;
            end else if (start_mret) begin
                is_mret_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d      = state_q;
        ready        = 1'b0;
        save_en      = 1'b0;
        trap_stat_en = 1'b0;
        mret_stat_en = 1'b0;
        done         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
                if (start_ecall) begin
                    state_d = ST_TRAP_SAVE;
                end else if (start_mret) begin
                    state_d = ST_MRET_STAT;
                end
            end
            ST_TRAP_SAVE: begin
                save_en = 1'b1;
                state_d = ST_TRAP_STAT;
            end
            ST_TRAP_STAT: begin
                trap_stat_en = 1'b1;
                state_d      = ST_DONE;
            end
            ST_MRET_STAT: begin
                mret_stat_en = 1'b1;
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done_is_mret = is_mret_q;

endmodule

// File: rtl/gpr_csr_file.sv
// RV32 architectural state: GPR file and machine-mode CSR unit.
// Holds GPRs, CSRs, the CSR RW/RS/RC datapath and the mcycle counter.
module gpr_csr_file
    import rf_pkg::*;
#(
    parameter int          NUM_GPR     = 16,
    parameter bit          BYPASS      = 1'b1,
    parameter bit          HAS_CYCLE   = 1'b1,
    parameter logic [31:0] MSTATUS_RST = 32'h1800,
    parameter int          AW          = $clog2(NUM_GPR)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic [31:0]   rs1_data,
    output logic [31:0]   rs2_data,
    input  logic          rd_wen,
    input  logic [AW-1:0] rd_addr,
    input  logic [31:0]   rd_wdata,
    input  logic          csr_valid,
    output logic          csr_ready,
    input  csr_cmd_e      csr_cmd,
    input  logic [11:0]   csr_addr,
    input  logic [31:0]   csr_wsrc,
    input  logic [31:0]   pc_cur,
    output logic          csr_done,
    output logic [31:0]   csr_rdata,
    output logic          illegal_csr,
    output logic          redirect_valid,
    output logic [31:0]   redirect_pc
);

    logic [31:0] gpr_q [NUM_GPR];

    logic [31:0] mstatus_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [31:0] trap_pc_q;

    logic        done_q;
    logic        ill_q;
    logic [31:0] rdata_q;

    logic        fsm_ready;
    logic        save_en;
    logic        trap_stat_en;
    logic        mret_stat_en;
    logic        fsm_done;
    logic        done_is_mret;

    logic        is_rmw;
    logic        csr_acc;
    logic        start_ecall;
    logic        start_mret;
    logic        csr_legal;
    logic [31:0] csr_old;
    logic [31:0] csr_new;
    logic        csr_wr;

    // Architectural register reads; x0 is hardwired, optional write-first bypass.
    function automatic logic [31:0] gpr_read(input logic [AW-1:0] a);
        logic [31:0] r;
        r = gpr_q[a];
        if (a == '0) begin
            r = '0;
        end else if (BYPASS && rd_wen && (rd_addr == a)) begin
            r = rd_wdata;
        end
        return r;
    endfunction

    assign rs1_data = gpr_read(rs1_addr);
    assign rs2_data = gpr_read(rs2_addr);

    // GPR array; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
        end else if (rd_wen && (rd_addr != '0)) begin
            gpr_q[rd_addr] <= rd_wdata;
        end
    end

    assign is_rmw = (csr_cmd == CMD_RW) ||
                    (csr_cmd == CMD_RS) ||
                    (csr_cmd == CMD_RC);

    assign csr_acc     = csr_valid && fsm_ready && is_rmw;
    assign start_ecall = csr_valid && fsm_ready && (csr_cmd == CMD_ECALL);
    assign start_mret  = csr_valid && fsm_ready && (csr_cmd == CMD_MRET);

    // CSR address decode and old-value read.
    always_comb begin
        csr_legal = 1'b1;
        csr_old   = '0;
        unique case (csr_addr)
            CSR_MSTATUS:  csr_old = mstatus_q;
            CSR_MTVEC:    csr_old = mtvec_q;
            CSR_MSCRATCH: csr_old = mscratch_q;
            CSR_MEPC:     csr_old = mepc_q;
            CSR_MCAUSE:   csr_old = mcause_q;
            CSR_MCYCLE: begin
                csr_legal = HAS_CYCLE;
                csr_old   = HAS_CYCLE ? mcycle_q[31:0] : '0;
            end
            CSR_MCYCLEH: begin
                csr_legal = HAS_CYCLE;
                csr_old   = HAS_CYCLE ? mcycle_q[63:32] : '0;
            end
            default: csr_legal = 1'b0;
        endcase
    end

    assign csr_new = csr_new_val(csr_cmd, csr_old, csr_wsrc);

    // Set/clear with a zero mask is a pure read.
    assign csr_wr = csr_acc && csr_legal &&
                    ((csr_cmd == CMD_RW) || (csr_wsrc != '0));

    // Machine CSRs: software writes plus trap entry/return updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_q  <= MSTATUS_RST;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= MCAUSE_RST;
            trap_pc_q  <= '0;
        end else begin
            if (start_ecall) begin
                trap_pc_q <= pc_cur;
            end
            if (save_en) begin
                mepc_q   <= {trap_pc_q[31:2], 2'b00};
                mcause_q <= ECALL_CAUSE;
            end
            if (trap_stat_en) begin
                mstatus_q[MSTATUS_MPIE] <= mstatus_q[MSTATUS_MIE];
                mstatus_q[MSTATUS_MIE]  <= 1'b0;
                mstatus_q[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
            end
            if (mret_stat_en) begin
                mstatus_q[MSTATUS_MIE]  <= mstatus_q[MSTATUS_MPIE];
                mstatus_q[MSTATUS_MPIE] <= 1'b1;
            end
            if (csr_wr) begin
                unique case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_q <= (mstatus_q & ~MSTATUS_WMASK) |
                                     (csr_new & MSTATUS_WMASK);
                    end
                    CSR_MTVEC:    mtvec_q    <= {csr_new[31:2], 2'b00};
                    CSR_MSCRATCH: mscratch_q <= csr_new;
                    CSR_MEPC:     mepc_q     <= {csr_new[31:2], 2'b00};
                    CSR_MCAUSE:   mcause_q   <= csr_new;
                    default: ;
                endcase
            end
        end
    end

    // Free-running cycle counter; a half written by software skips the increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcycle_q <= '0;
        end else if (csr_wr && (csr_addr == CSR_MCYCLE)) begin
            mcycle_q[31:0] <= csr_new;
        end else if (csr_wr && (csr_addr == CSR_MCYCLEH)) begin
            mcycle_q[63:32] <= csr_new;
        end else begin
            mcycle_q <= mcycle_q + 64'd1;
        end
    end

    // One-cycle response for RW/RS/RC; rdata is zero outside a legal response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            done_q  <= csr_acc;
            ill_q   <= csr_acc && !csr_legal;
            rdata_q <= (csr_acc && csr_legal) ? csr_old : '0;
        end
    end

    csr_trap_fsm u_fsm (
        .clk          (clk),
        .rst          (rst),
        .start_ecall  (start_ecall),
        .start_mret   (start_mret),
        .ready        (fsm_ready),
        .save_en      (save_en),
        .trap_stat_en (trap_stat_en),
        .mret_stat_en (mret_stat_en),
        .done         (fsm_done),
        .done_is_mret (done_is_mret)
    );

    assign csr_ready      = fsm_ready;
    assign csr_done       = done_q | fsm_done;
    assign csr_rdata      = rdata_q;
    assign illegal_csr    = ill_q;
    assign redirect_valid = fsm_done;
    assign redirect_pc    = fsm_done ? (done_is_mret ? mepc_q : mtvec_q) : '0;

endmodule

// File: tb/tb_gpr_csr_file.sv
// Directed bench for gpr_csr_file: GPR file, CSR ops, traps, mcycle.
// Table-driven CSR vectors plus hand sequences for ECALL/MRET and reset abort.
module tb_gpr_csr_file;
    import rf_pkg::*;

    localparam int AW = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic [31:0]   rs1_data;
    logic [31:0]   rs2_data;
    logic          rd_wen;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_wdata;
    logic          csr_valid;
    logic          csr_ready;
    csr_cmd_e      csr_cmd;
    logic [11:0]   csr_addr;
    logic [31:0]   csr_wsrc;
    logic [31:0]   pc_cur;
    logic          csr_done;
    logic [31:0]   csr_rdata;
    logic          illegal_csr;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;

    int n_pass;
    int n_total;

    gpr_csr_file #(
        .NUM_GPR     (16),
        .BYPASS      (1'b1),
        .HAS_CYCLE   (1'b1),
        .MSTATUS_RST (32'h1800)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .rs1_data       (rs1_data),
        .rs2_data       (rs2_data),
        .rd_wen         (rd_wen),
        .rd_addr        (rd_addr),
        .rd_wdata       (rd_wdata),
        .csr_valid      (csr_valid),
        .csr_ready      (csr_ready),
        .csr_cmd        (csr_cmd),
        .csr_addr       (csr_addr),
        .csr_wsrc       (csr_wsrc),
        .pc_cur         (pc_cur),
        .csr_done       (csr_done),
        .csr_rdata      (csr_rdata),
        .illegal_csr    (illegal_csr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        csr_cmd_e    cmd;
        logic [11:0] addr;
        logic [31:0] wsrc;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gpr_write(input logic [AW-1:0] a, input logic [31:0] d);
        rd_wen   = 1'b1;
        rd_addr  = a;
        rd_wdata = d;
        tick();
        rd_wen = 1'b0;
    endtask

    task automatic csr_op(input csr_cmd_e cmd, input logic [11:0] a,
                          input logic [31:0] w);
        csr_valid = 1'b1;
        csr_cmd   = cmd;
        csr_addr  = a;
        csr_wsrc  = w;
        tick();
        csr_valid = 1'b0;
        csr_cmd   = CMD_NOP;
    endtask

    task automatic csr_rd(input string name, input logic [11:0] a,
                          input logic [31:0] exp);
        csr_op(CMD_RS, a, 32'h0);
        chk(name, csr_rdata, exp);
    endtask

    // Waits out a trap sequence, recording when redirect fires and ready returns.
    task automatic trap_wait(output int red_at, output int rdy_at,
                             output logic [31:0] rpc, output logic rdone);
        red_at = 0;
        rdy_at = 0;
        rpc    = '0;
        rdone  = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (redirect_valid && red_at == 0) begin
                red_at = i;
                rpc    = redirect_pc;
                rdone  = csr_done;
            end
            if (csr_ready) begin
                rdy_at = i;
                break;
            end
            tick();
        end
    endtask

    initial begin
        int          red_at;
        int          rdy_at;
        logic [31:0] rpc;
        logic        rdone;

        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        rs1_addr  = '0;
        rs2_addr  = '0;
        rd_wen    = 1'b0;
        rd_addr   = '0;
        rd_wdata  = '0;
        csr_valid = 1'b0;
        csr_cmd   = CMD_NOP;
        csr_addr  = '0;
        csr_wsrc  = '0;
        pc_cur    = '0;

        vecs[0]  = '{CMD_RW, CSR_MSCRATCH, 32'h0000_1234, 32'h0, 1'b0};
        vecs[1]  = '{CMD_RC, CSR_MSCRATCH, 32'h0000_0004, 32'h1234, 1'b0};
        vecs[2]  = '{CMD_RS, CSR_MSCRATCH, 32'h0, 32'h1230, 1'b0};
        vecs[3]  = '{CMD_RW, 12'h7C0, 32'hFFFF_FFFF, 32'h0, 1'b1};
        vecs[4]  = '{CMD_RS, CSR_MSCRATCH, 32'h0, 32'h1230, 1'b0};
        vecs[5]  = '{CMD_RS, CSR_MSTATUS, 32'h0, 32'h1800, 1'b0};
        vecs[6]  = '{CMD_RW, CSR_MTVEC, 32'h8000_0103, 32'h0, 1'b0};
        vecs[7]  = '{CMD_RS, CSR_MTVEC, 32'h0, 32'h8000_0100, 1'b0};
        vecs[8]  = '{CMD_RS, CSR_MCAUSE, 32'h0, 32'hb, 1'b0};
        vecs[9]  = '{CMD_RS, CSR_MSTATUS, 32'h8, 32'h1800, 1'b0};
        vecs[10] = '{CMD_RS, CSR_MSTATUS, 32'h0, 32'h1808, 1'b0};
        vecs[11] = '{CMD_RW, CSR_MEPC, 32'h0000_0007, 32'h0, 1'b0};
        vecs[12] = '{CMD_RC, CSR_MEPC, 32'h0, 32'h4, 1'b0};

        #12;
        chk("rst_ready", {31'b0, csr_ready}, 32'h1);
        chk("rst_done", {31'b0, csr_done}, 32'h0);
        chk("rst_redirect", {31'b0, redirect_valid}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_rdata", csr_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        gpr_write(4'd5, 32'hDEAD_BEEF);
        gpr_write(4'd0, 32'h1);
        rs1_addr = 4'd5;
        rs2_addr = 4'd0;
        #1;
        chk("gpr_x5", rs1_data, 32'hDEAD_BEEF);
        chk("gpr_x0", rs2_data, 32'h0);

        rd_wen   = 1'b1;
        rd_addr  = 4'd7;
        rd_wdata = 32'hCAFE_F00D;
        rs1_addr = 4'd7;
        #1;
        chk("gpr_bypass", rs1_data, 32'hCAFE_F00D);
        chk("gpr_bypass_other", rs2_data, 32'h0);
        tick();
        rd_wen = 1'b0;
        #1;
        chk("gpr_x7_commit", rs1_data, 32'hCAFE_F00D);

        rd_wen   = 1'b1;
        rd_addr  = 4'd9;
        rd_wdata = 32'h0000_0099;
        csr_valid = 1'b1;
        csr_cmd   = CMD_RW;
        csr_addr  = CSR_MSCRATCH;
        csr_wsrc  = 32'h0000_5555;
        tick();
        rd_wen    = 1'b0;
        csr_valid = 1'b0;
        csr_cmd   = CMD_NOP;
        rs1_addr  = 4'd9;
        #1;
        chk("gpr_csr_same_cycle_gpr", rs1_data, 32'h99);
        chk("gpr_csr_same_cycle_done", {31'b0, csr_done}, 32'h1);
        csr_op(CMD_RW, CSR_MSCRATCH, 32'h0);
        chk("mscratch_5555", csr_rdata, 32'h5555);

        for (int i = 0; i < 13; i++) begin
            csr_op(vecs[i].cmd, vecs[i].addr, vecs[i].wsrc);
            chk($sformatf("vec%0d_done", i), {31'b0, csr_done}, 32'h1);
            chk($sformatf("vec%0d_rdata", i), csr_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_illegal", i), {31'b0, illegal_csr},
                {31'b0, vecs[i].exp_ill});
        end
        tick();
        chk("done_drops", {31'b0, csr_done}, 32'h0);
        chk("illegal_drops", {31'b0, illegal_csr}, 32'h0);

        csr_op(CMD_NOP, CSR_MSCRATCH, 32'h1);
        chk("nop_no_done", {31'b0, csr_done}, 32'h0);

        csr_op(CMD_RW, CSR_MCYCLEH, 32'hFFFF_FFFF);
        csr_op(CMD_RW, CSR_MCYCLE, 32'hFFFF_FFFF);
        csr_rd("mcycle_max", CSR_MCYCLE, 32'hFFFF_FFFF);
        csr_rd("mcycleh_wrap", CSR_MCYCLEH, 32'h0);
        csr_rd("mcycle_after_wrap", CSR_MCYCLE, 32'h1);

        csr_op(CMD_RW, CSR_MEPC, 32'h0);
        pc_cur = 32'h8000_0040;
        csr_op(CMD_ECALL, 12'h0, 32'h0);
        chk("ecall_ready_low", {31'b0, csr_ready}, 32'h0);
        trap_wait(red_at, rdy_at, rpc, rdone);
        chk("ecall_redirect_cycle", red_at, 3);
        chk("ecall_ready_back", rdy_at, 4);
        chk("ecall_redirect_pc", rpc, 32'h8000_0100);
        chk("ecall_done", {31'b0, rdone}, 32'h1);
        csr_rd("ecall_mepc", CSR_MEPC, 32'h8000_0040);
        csr_rd("ecall_mcause", CSR_MCAUSE, 32'hb);
        csr_rd("ecall_mstatus", CSR_MSTATUS, 32'h1880);

        csr_op(CMD_MRET, 12'h0, 32'h0);
        trap_wait(red_at, rdy_at, rpc, rdone);
        chk("mret_redirect_cycle", red_at, 2);
        chk("mret_ready_back", rdy_at, 3);
        chk("mret_redirect_pc", rpc, 32'h8000_0040);
        csr_rd("mret_mstatus", CSR_MSTATUS, 32'h1888);

        pc_cur = 32'h8000_0080;
        csr_op(CMD_ECALL, 12'h0, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("abort_redirect", {31'b0, redirect_valid}, 32'h0);
        chk("abort_ready", {31'b0, csr_ready}, 32'h1);
        tick();
        chk("abort_redirect_hold", {31'b0, redirect_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("abort_redirect_after", {31'b0, redirect_valid}, 32'h0);
        csr_rd("abort_mstatus", CSR_MSTATUS, 32'h1800);
        chk("abort_accept_done", {31'b0, csr_done}, 32'h1);
        csr_rd("abort_mepc", CSR_MEPC, 32'h0);
        csr_rd("abort_mscratch", CSR_MSCRATCH, 32'h0);
        rs1_addr = 4'd5;
        #1;
        chk("abort_gpr_cleared", rs1_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
